hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Sequential hazard and pipeline-sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB) that sits around the decode controller.
- Keeps shadow copies of the destination/source info for the EX, MEM and WB occupants.
- Detects load-use and control hazards and drives pipeline register enables, flushes and forwarding-mux selects.
- Counts stall and flush cycles for performance debug.

Parameters:
CNT_W, 32, width of stall/flush performance counters (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_inst  in  32  instruction currently in the IF/ID register
id_valid  in  1  IF/ID holds a real instruction (0 = bubble)
ex_pcsel  in  1  PCsel from the EX-stage instruction; 1 = taken branch or jump
mem_busy  in  1  data memory not ready; whole pipeline must hold
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID becomes bubble on next edge
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX becomes bubble on next edge
back_en  out  1  EX/MEM and MEM/WB enables
fwd_a  out  2  EX operand-A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write-back data
fwd_b  out  2  EX operand-B source, same encoding
stall_cnt  out  CNT_W  load-use stall cycles since reset
flush_cnt  out  CNT_W  redirect flush events since reset

Behaviour:
- Local decode of id_inst[6:2]:
  - uses_rs1 for R, I-arith, load, store, branch, JALR.
  - uses_rs2 for R, store, branch.
  - wen for R, I-arith, load, LUI, AUIPC, JAL, JALR.
  - is_load for opcode 00000.
  - Unknown opcode: no sources, wen=0.
- Shadow entries EX, MEM, WB each hold {v, rd[4:0], wen, load, rs1[4:0], rs2[4:0]}. An entry is a hazard producer only if v & wen & rd!=0.
- Priority, evaluated combinationally every cycle:
  - 1. mem_busy=1:
    - pc_en, ifid_en, idex_en and back_en all 0; no flushes.
    - Shadows hold. Counters hold.
  - 2. ex_pcsel=1 (redirect):
    - pc_en=1, ifid_flush=1, idex_flush=1, back_en=1.
    - Next EX shadow becomes invalid, MEM<=EX, WB<=MEM.
    - flush_cnt+1.
    - A simultaneous load-use is ignored because the ID instruction is squashed.
  - 3. Load-use:
    - Condition: id_valid & EX is producer & EX.load & ((uses_rs1 & rs1==EX.rd) | (uses_rs2 & rs2==EX.rd)).
    - pc_en=0, ifid_en=0, idex_flush=1, back_en=1.
    - EX shadow becomes invalid; MEM<=EX, WB<=MEM.
    - stall_cnt+1.
  - 4. Otherwise:
    - All enables 1, no flushes.
    - EX shadow <= ID decode, with v=id_valid; MEM<=EX, WB<=MEM.
- Exactly one stall cycle per load-use. After the bubble, the load is in MEM and is forwarded from MEM/WB (fwd=10) on the following cycle.
- Forwarding (combinational from shadows), for EX operand A using EX.rs1, B using EX.rs2:
  - 01 if MEM is producer & !MEM.load & MEM.rd==rs.
  - Else 10 if WB is producer & WB.rd==rs.
  - Else 00.
  - MEM has priority over WB (youngest value wins).
  - rs==0 always gives 00.
  - An invalid EX shadow gives 00.
- Register file is write-first; no WB-to-ID bypass is generated here.
- Counters saturate at all-ones and never wrap.
- Reset (async, immediate):
  - All shadows v=0, counters 0.
  - Outputs take idle values: pc_en=ifid_en=idex_en=back_en=1, flushes 0, fwd 00.
- Reset mid-stall clears the stall in the same cycle reset is asserted.
- Latency: all control outputs are combinational from current inputs and shadows. Shadow updates occur on the rising edge.

Decomposition:
- Package hazard_pkg holds:
  - opcode[6:2] localparams: OP_R=01100, OP_I=00100, OP_LD=00000, OP_ST=01000, OP_BR=11000, OP_LUI=01101, OP_AUIPC=00101, OP_JAL=11011, OP_JALR=11001.
  - FWD_RF/FWD_MEM/FWD_WB encodings.
  - The shadow-entry field widths.
- One sub-module, hazard_dec: combinational id_inst -> {uses_rs1, uses_rs2, wen, load, rs1, rs2, rd}. It is reusable by a future scoreboard.

Test Plan:
- Load-use: id_inst=0x0000A283 (lw x5,0(x1)), next 0x00228333 (add x6,x5,x2) -> one cycle of pc_en=0/ifid_en=0/idex_flush=1, stall_cnt=1. Two cycles later fwd_a=10, fwd_b=00.
- ALU chain: 0x00100293 (addi x5,x0,1) then 0x005283B3 (add x7,x5,x5) -> no stall; fwd_a=fwd_b=01 when add is in EX.
- Priority/x0: three writers to x5 back-to-back -> EX consumer gets 01, not 10. Any rd=x0 producer never triggers stall or forward.
- Redirect plus load-use: ex_pcsel=1 in the same cycle as a load-use condition -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
- mem_busy for 3 cycles during a load-use window -> all enables 0, shadows and counters frozen. The stall resolves normally after mem_busy drops.
- Async rst asserted mid-stall between clock edges -> outputs return to idle values immediately and counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: opcode groups,
// forwarding-mux encodings, decoded-instruction and shadow-entry layouts.
package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_ST    = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             uses_rs1;
    logic             uses_rs2;
    logic             wen;
    logic             load;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } dec_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             load;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // Which priority branch the controller is taking this cycle.
  typedef enum logic [1:0] {
    M_RUN      = 2'b00,
    M_HOLD     = 2'b01,
    M_REDIRECT = 2'b10,
    M_STALL    = 2'b11
  } mode_t;

  function automatic logic is_producer(input shadow_t s);
    return s.v & s.wen & (s.rd != '0);
  endfunction

  // Youngest producer wins; a load still in MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input shadow_t mem_s,
                                         input shadow_t wb_s);
    if (rs == '0)
      return FWD_RF;
    else if (is_producer(mem_s) && !mem_s.load && mem_s.rd == rs)
      return FWD_MEM;
    else if (is_producer(wb_s) && wb_s.rd == rs)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// No valid/ready pairs here: mem_busy=1 freezes every stage, id_valid=0 marks a bubble.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             ex_pcsel;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             back_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_inst, id_valid, ex_pcsel, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, back_en,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_inst, id_valid, ex_pcsel, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, back_en,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_dec.sv
// Minimal register-usage decode of a RISC-V instruction word.
// Unused source fields are zeroed so downstream compares need not re-check uses_rsN.
module hazard_dec
  import hazard_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);
  logic [4:0] opcode;
  logic       unused_bits;

  assign opcode      = inst[6:2];
  assign unused_bits = ^{inst[31:25], inst[14:12], inst[1:0]};

  always_comb begin
    dec          = '0;
    dec.rd       = inst[11:7];
    unique case (opcode)
      OP_R:     begin dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.wen = 1'b1; end
      OP_I:     begin dec.uses_rs1 = 1'b1; dec.wen = 1'b1; end
      OP_LD:    begin dec.uses_rs1 = 1'b1; dec.wen = 1'b1; dec.load = 1'b1; end
      OP_ST:    begin dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; end
      OP_BR:    begin dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; end
      OP_LUI:   dec.wen = 1'b1;
      OP_AUIPC: dec.wen = 1'b1;
      OP_JAL:   dec.wen = 1'b1;
      OP_JALR:  begin dec.uses_rs1 = 1'b1; dec.wen = 1'b1; end
      default:  dec.wen = 1'b0;
    endcase
    dec.rs1 = dec.uses_rs1 ? inst[19:15] : '0;
    dec.rs2 = dec.uses_rs2 ? inst[24:20] : '0;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: tracks EX/MEM/WB
// occupants, resolves load-use and redirect hazards, selects forwarding sources.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);
  dec_t             id_dec;
  shadow_t          ex_q, mem_q, wb_q, ex_next;
  mode_t            mode;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_dec u_dec (.inst(bus.id_inst), .dec(id_dec));

  assign ex_next = '{v: bus.id_valid, rd: id_dec.rd, wen: id_dec.wen, load: id_dec.load,
                     rs1: id_dec.rs1, rs2: id_dec.rs2};

  assign load_use = bus.id_valid & is_producer(ex_q) & ex_q.load &
                    ((id_dec.uses_rs1 & (id_dec.rs1 == ex_q.rd)) |
                     (id_dec.uses_rs2 & (id_dec.rs2 == ex_q.rd)));

  // Reset forces the idle mode so outputs go quiet before any clock edge.
  always_comb begin
    mode = M_RUN;
    if (rst)               mode = M_RUN;
    else if (bus.mem_busy) mode = M_HOLD;
    else if (bus.ex_pcsel) mode = M_REDIRECT;
    else if (load_use)     mode = M_STALL;
  end

  always_comb begin
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_en    = 1'b1;
    bus.idex_flush = 1'b0;
    bus.back_en    = 1'b1;
    unique case (mode)
      M_HOLD: begin
        bus.pc_en   = 1'b0;
        bus.ifid_en = 1'b0;
        bus.idex_en = 1'b0;
        bus.back_en = 1'b0;
      end
      M_REDIRECT: begin
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end
      M_STALL: begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fwd_a     = ex_q.v ? fwd_sel(ex_q.rs1, mem_q, wb_q) : FWD_RF;
  assign bus.fwd_b     = ex_q.v ? fwd_sel(ex_q.rs2, mem_q, wb_q) : FWD_RF;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= SHADOW_EMPTY;
      mem_q     <= SHADOW_EMPTY;
      wb_q      <= SHADOW_EMPTY;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (mode)
        M_HOLD: ;
        M_REDIRECT: begin
          ex_q  <= SHADOW_EMPTY;
          mem_q <= ex_q;
          wb_q  <= mem_q;
          if (!(&flush_cnt)) flush_cnt <= flush_cnt + CNT_ONE;
        end
        M_STALL: begin
          ex_q  <= SHADOW_EMPTY;
          mem_q <= ex_q;
          wb_q  <= mem_q;
          if (!(&stall_cnt)) stall_cnt <= stall_cnt + CNT_ONE;
        end
        default: begin
          ex_q  <= ex_next;
          mem_q <= ex_q;
          wb_q  <= mem_q;
        end
      endcase
    end
  end
endmodule
